sram_bist_checker: RTL and testbench

Master-side consumer of the deterministic pattern-generator interface. It advances a pattern generator, turns each generated step into a registered SRAM command, and aligns read data with the generator's expected value across a configurable read latency. It compares, counts and logs mismatches, then reports pass/fail once the generator signals completion. It sits between any pattern generator and the SRAM macro in the BIST wrapper.

---
 rtl/sram_bist_checker.sv | 148 ++++++++++++++
 tb/tb_sram_bist_checker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_checker.sv
// Drives SRAM commands from a pattern generator and checks read data against the expected word.
// Latency: command registered 1 cycle after the step; mismatch visible READ_LATENCY+1 cycles after the command.
// Backpressure: none; the generator is stepped by pg_en and the SRAM takes one command per cycle.
module sram_bist_checker #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int MASK_WIDTH    = 4,
    parameter int READ_LATENCY  = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     pg_en,
    input  logic [ADDR_WIDTH-1:0]    pg_addr,
    input  logic [DATA_WIDTH-1:0]    pg_data,
    input  logic [DATA_WIDTH-1:0]    pg_check,
    input  logic [MASK_WIDTH-1:0]    pg_wmask,
    input  logic                     pg_we,
    input  logic                     pg_re,
    input  logic                     pg_done,
    output logic                     sram_ce,
    output logic                     sram_we,
    output logic [ADDR_WIDTH-1:0]    sram_addr,
    output logic [DATA_WIDTH-1:0]    sram_din,
    output logic [MASK_WIDTH-1:0]    sram_wmask,
    input  logic [DATA_WIDTH-1:0]    sram_dout,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     fail_valid,
    output logic [ADDR_WIDTH-1:0]    fail_addr,
    output logic [DATA_WIDTH-1:0]    fail_expected,
    output logic [DATA_WIDTH-1:0]    fail_actual
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int DCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(READ_LATENCY - 1);
    // Stage 0 sits alongside the command register; the last stage lines up with sram_dout.
    localparam int PD = READ_LATENCY + 1;

    state_t state, state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic step_vld, rd_issue, start_run, cmp_fail;

    logic                  pipe_vld  [PD];
    logic [ADDR_WIDTH-1:0] pipe_addr [PD];
    logic [DATA_WIDTH-1:0] pipe_chk  [PD];

    assign pg_en     = (state == RUN) && !pg_done;
    assign step_vld  = pg_en && (pg_we || pg_re);
    assign rd_issue  = step_vld && !pg_we;
    assign start_run = (state == IDLE) && start;
    assign cmp_fail  = pipe_vld[PD-1] && (sram_dout != pipe_chk[PD-1]);

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (pg_done) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_din   <= '0;
            sram_wmask <= '0;
        end else begin
            sram_ce <= step_vld;
            sram_we <= step_vld && pg_we;
            if (step_vld) begin
                sram_addr  <= pg_addr;
                sram_din   <= pg_data;
                sram_wmask <= pg_wmask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PD; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= '0;
                pipe_chk[i]  <= '0;
            end
        end else if (start_run) begin
            for (int i = 0; i < PD; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0]  <= rd_issue;
            pipe_addr[0] <= pg_addr;
            pipe_chk[0]  <= pg_check;
            for (int i = 1; i < PD; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_chk[i]  <= pipe_chk[i-1];
            end
        end
    end

    // Only the first mismatch is logged; the counter keeps going until it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count     <= '0;
            fail_valid    <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else if (start_run) begin
            err_count     <= '0;
            fail_valid    <= 1'b0;
            fail_addr     <= '0;
            fail_expected <= '0;
            fail_actual   <= '0;
        end else if (cmp_fail) begin
            if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
            if (!fail_valid) begin
                fail_valid    <= 1'b1;
                fail_addr     <= pipe_addr[PD-1];
                fail_expected <= pipe_chk[PD-1];
                fail_actual   <= sram_dout;
            end
        end
    end

endmodule

// File: tb/tb_sram_bist_checker.sv
// Bench for sram_bist_checker: two instances (READ_LATENCY 1 with a 2-bit counter, READ_LATENCY 3),
// each with its own march generator and fault-injecting behavioural SRAM.
module tb_sram_bist_checker;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] chk;
    } step_t;

    typedef struct packed {
        logic [15:0] ec;
        logic        fv;
        logic [3:0]  fa;
        logic [7:0]  fe;
        logic [7:0]  fact;
        logic        ps;
    } res_t;

    logic clk, rst;
    logic        start      [2];
    logic        pg_en      [2];
    logic        pgd        [2];
    logic        sram_ce    [2];
    logic        sram_we    [2];
    logic [3:0]  sram_addr  [2];
    logic [7:0]  sram_din   [2];
    logic [3:0]  wmask      [2];
    logic        busy       [2];
    logic        done       [2];
    logic        pass       [2];
    logic [15:0] errc       [2];
    logic        fail_valid [2];
    logic [3:0]  fail_addr  [2];
    logic [7:0]  fail_exp   [2];
    logic [7:0]  fail_act   [2];

    logic [7:0] stk1 [2][16];
    logic [7:0] stk0 [2][16];
    logic       inv  [2];

    int n_cmp = 0;
    int n_mis = 0;

    step_t cmd_q[$];
    res_t  res_q[$];

    // March: write-0, read-0, write-1, read-1 over 16 words, one step per pg_en.
    function automatic step_t gen(input int s);
        step_t r;
        int ph;
        r  = '0;
        ph = s / 16;
        if (s < 64) begin
            r.addr = 4'(s % 16);
            r.we   = (ph == 0) || (ph == 2);
            r.re   = (ph == 1) || (ph == 3);
            r.data = (ph >= 2) ? 8'hFF : 8'h00;
            r.chk  = r.data;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_h
        localparam int RL = (g == 0) ? 1 : 3;
        localparam int EW = (g == 0) ? 2 : 16;
        int            stp;
        step_t         cur;
        logic [7:0]    mem [16];
        logic [7:0]    dq  [RL];
        logic [EW-1:0] ec;
        logic [7:0]    bm;

        assign cur      = gen(stp);
        assign pgd[g]   = (stp >= 64);
        assign errc[g]  = 16'(ec);
        assign bm = {{2{wmask[g][3]}}, {2{wmask[g][2]}}, {2{wmask[g][1]}}, {2{wmask[g][0]}}};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) stp <= 0;
            else if (pg_en[g]) stp <= stp + 1;
        end

        always_ff @(posedge clk) begin
            if (sram_ce[g] && sram_we[g])
                mem[sram_addr[g]] <= (mem[sram_addr[g]] & ~bm) | (sram_din[g] & bm);
            if (sram_ce[g] && !sram_we[g])
                dq[0] <= ((mem[sram_addr[g]] | stk1[g][sram_addr[g]]) & ~stk0[g][sram_addr[g]])
                         ^ {8{inv[g]}};
            for (int i = 1; i < RL; i++) dq[i] <= dq[i-1];
        end

        sram_bist_checker #(
            .ADDR_WIDTH(4), .DATA_WIDTH(8), .MASK_WIDTH(4),
            .READ_LATENCY(RL), .ERR_CNT_WIDTH(EW)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start[g]), .pg_en(pg_en[g]),
            .pg_addr(cur.addr), .pg_data(cur.data), .pg_check(cur.chk), .pg_wmask(4'hF),
            .pg_we(cur.we), .pg_re(cur.re), .pg_done(pgd[g]),
            .sram_ce(sram_ce[g]), .sram_we(sram_we[g]), .sram_addr(sram_addr[g]),
            .sram_din(sram_din[g]), .sram_wmask(wmask[g]), .sram_dout(dq[RL-1]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]), .err_count(ec),
            .fail_valid(fail_valid[g]), .fail_addr(fail_addr[g]),
            .fail_expected(fail_exp[g]), .fail_actual(fail_act[g])
        );
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] outs(input int g);
        return 64'({pg_en[g], sram_ce[g], sram_we[g], sram_addr[g], sram_din[g], wmask[g],
                    busy[g], done[g], pass[g], errc[g], fail_valid[g], fail_addr[g],
                    fail_exp[g], fail_act[g]});
    endfunction

    // Expected end-of-run result from a behavioural memory with the same faults.
    function automatic res_t model(input int g);
        res_t r;
        logic [7:0] mm [16];
        logic [7:0] v;
        step_t st;
        int maxc;
        r    = '0;
        maxc = (g == 0) ? 3 : 65535;
        for (int i = 0; i < 16; i++) mm[i] = 8'h00;
        for (int s = 0; s < 64; s++) begin
            st = gen(s);
            if (st.we) mm[st.addr] = st.data;
            else if (st.re) begin
                v = ((mm[st.addr] | stk1[g][st.addr]) & ~stk0[g][st.addr]) ^ {8{inv[g]}};
                if (v != st.chk) begin
                    if (int'(r.ec) < maxc) r.ec = r.ec + 16'd1;
                    if (!r.fv) begin
                        r.fv = 1'b1; r.fa = st.addr; r.fe = st.chk; r.fact = v;
                    end
                end
            end
        end
        r.ps = (r.ec == 16'd0);
        return r;
    endfunction

    task automatic clear_faults();
        for (int g = 0; g < 2; g++) begin
            inv[g] = 1'b0;
            for (int a = 0; a < 16; a++) begin
                stk1[g][a] = 8'h00;
                stk0[g][a] = 8'h00;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_test(input int g, input string name, input bit poke);
        int cyc, d_cyc, first_ce, last_ce, mstep, ncmd, rl;
        step_t e;
        res_t exp_r, got;
        rl = (g == 0) ? 1 : 3;
        exp_r = model(g);
        res_q.push_back(exp_r);
        cmd_q.delete();
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        n_cmp++;
        if ({pg_en[g], busy[g], sram_ce[g]} !== 3'b110) begin
            n_mis++;
            $display("FAIL %s_start: pg_en/busy/ce=%b required 110", name,
                     {pg_en[g], busy[g], sram_ce[g]});
        end
        cyc = 0; d_cyc = -1; first_ce = -1; last_ce = -1; mstep = 0; ncmd = 0;
        while (!done[g] && cyc < 400) begin
            if (sram_ce[g]) begin
                n_cmp++;
                if (cmd_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL %s_cmd: unexpected command at cycle %0d", name, cyc);
                end else begin
                    e = cmd_q.pop_front();
                    if ({sram_we[g], sram_addr[g], sram_din[g]} !== {e.we, e.addr, e.data}) begin
                        n_mis++;
                        $display("FAIL %s_cmd: we/addr/din=%b/%0h/%0h required %b/%0h/%0h", name,
                                 sram_we[g], sram_addr[g], sram_din[g], e.we, e.addr, e.data);
                    end
                end
                ncmd++;
                if (first_ce < 0) first_ce = cyc;
                last_ce = cyc;
            end
            if (pg_en[g]) begin
                cmd_q.push_back(gen(mstep));
                mstep++;
            end
            if (pgd[g] && d_cyc < 0) d_cyc = cyc;
            start[g] = poke && (cyc == 20);
            @(negedge clk);
            cyc++;
        end
        start[g] = 1'b0;
        n_cmp++;
        if (!done[g]) begin
            n_mis++;
            $display("FAIL %s_timeout: done never rose within 400 cycles", name);
        end else begin
            n_cmp++;
            if (ncmd != 64 || last_ce - first_ce != 63 || cmd_q.size() != 0) begin
                n_mis++;
                $display("FAIL %s_stream: cmds=%0d span=%0d left=%0d required 64/63/0", name,
                         ncmd, last_ce - first_ce, cmd_q.size());
            end
            n_cmp++;
            if (cyc - d_cyc != rl + 1) begin
                n_mis++;
                $display("FAIL %s_done_lat: %0d cycles required %0d", name, cyc - d_cyc, rl + 1);
            end
            got = {errc[g], fail_valid[g], fail_addr[g], fail_exp[g], fail_act[g], pass[g]};
            exp_r = res_q.pop_front();
            n_cmp++;
            if (got.ec !== exp_r.ec) begin
                n_mis++;
                $display("FAIL %s_err_count: %0d required %0d", name, got.ec, exp_r.ec);
            end
            n_cmp++;
            if ({got.fv, got.fa, got.fe, got.fact} !== {exp_r.fv, exp_r.fa, exp_r.fe, exp_r.fact}) begin
                n_mis++;
                $display("FAIL %s_fail_log: v/addr/exp/act=%b/%0h/%0h/%0h required %b/%0h/%0h/%0h",
                         name, got.fv, got.fa, got.fe, got.fact,
                         exp_r.fv, exp_r.fa, exp_r.fe, exp_r.fact);
            end
            n_cmp++;
            if (got.ps !== exp_r.ps) begin
                n_mis++;
                $display("FAIL %s_pass: %b required %b", name, got.ps, exp_r.ps);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        clear_faults();
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_cmp++;
            if (outs(g) !== 64'd0) begin
                n_mis++;
                $display("FAIL reset_outputs[%0d]: %0h required 0", g, outs(g));
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean(input int g);
        clear_faults();
        do_reset();
        run_test(g, (g == 0) ? "clean_rl1" : "clean_rl3", 1'b0);
    endtask

    task automatic test_stuck_single(input int g);
        clear_faults();
        stk1[g][5] = 8'h08;
        do_reset();
        run_test(g, (g == 0) ? "sa1_rl1" : "sa1_rl3", 1'b0);
    endtask

    task automatic test_stuck_pair(input int g);
        clear_faults();
        stk0[g][2] = 8'h01;
        stk1[g][9] = 8'h80;
        do_reset();
        run_test(g, (g == 0) ? "pair_rl1" : "pair_rl3", 1'b0);
    endtask

    task automatic test_saturation();
        clear_faults();
        inv[0] = 1'b1;
        do_reset();
        run_test(0, "saturate", 1'b0);
    endtask

    task automatic test_robustness();
        int nrd, cyc;
        clear_faults();
        stk1[0][5] = 8'h08;
        do_reset();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        nrd = 0;
        cyc = 0;
        while (nrd < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (sram_ce[0] && !sram_we[0]) nrd++;
        end
        n_cmp++;
        if (errc[0] !== 16'd1 || fail_valid[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL pre_rst_log: err=%0d fv=%b required 1/1", errc[0], fail_valid[0]);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (outs(0) !== 64'd0) begin
            n_mis++;
            $display("FAIL midrun_rst: outputs %0h required 0", outs(0));
        end
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        @(negedge clk);
        run_test(0, "restart", 1'b1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({done[0], busy[0], pass[0], errc[0]} !== {3'b101, 16'd0}) begin
            n_mis++;
            $display("FAIL done_sticky: done/busy/pass/err=%b/%b/%b/%0d required 1/0/1/0",
                     done[0], busy[0], pass[0], errc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_clean(0);
        test_stuck_single(0);
        test_stuck_pair(0);
        test_saturation();
        test_clean(1);
        test_stuck_single(1);
        test_stuck_pair(1);
        test_robustness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
